// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense path (sequencer and credit unit).
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBIT,
        ST_MOTOR,
        ST_DROP,
        ST_DONE,
        ST_FAIL
    } vend_state_t;

    typedef enum logic [1:0] {
        FAIL_NONE     = 2'b00,
        FAIL_EMPTY    = 2'b01,
        FAIL_NOCREDIT = 2'b10,
        FAIL_JAM      = 2'b11
    } fail_code_t;

    // Price of one can, shared with the credit unit.
    localparam logic [7:0] COST = 8'd25;

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick: first pending slot at or after ptr, wrapping.
module vend_rr_arbiter #(
    parameter int SLOTS = 4,
    parameter int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] pend,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        for (int off = 0; off < SLOTS; off++) begin
            idx = int'(ptr) + off;
            if (idx >= SLOTS) idx = idx - SLOTS;
            if (!valid && pend[idx]) begin
                valid = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: RR slot grant, credit debit handshake, motor pulse, drop check.
// Build option: define DROP_SENSE_EN to enable the drop sensor, timeout/JAM, refund and faults.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int SLOTS        = 4,
    parameter int STOCK_W      = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 32,
    parameter int IDX_W        = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SLOTS-1:0] sel_req,
    input  logic [SLOTS-1:0] restock,
    output logic             debit_req,
    output logic [IDX_W-1:0] debit_slot,
    input  logic             debit_ack,
    input  logic             debit_nack,
    output logic             refund,
    output logic [SLOTS-1:0] motor_en,
    input  logic             drop_sense,
    output logic             vend_done,
    output logic             vend_fail,
    output logic [1:0]       fail_code,
    output logic [IDX_W-1:0] active_slot,
    output logic [SLOTS-1:0] slot_avail,
    output logic             busy
);

    localparam int CNT_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [STOCK_W-1:0] FULL = '1;

    vend_state_t        state_q, state_d;
    fail_code_t         code_q, code_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_seen_q, drop_seen_d;
    logic [SLOTS-1:0]   pend_q, pend_d;
    logic [SLOTS-1:0]   fault_q, fault_d;
    logic [STOCK_W-1:0] stock_q [SLOTS];
    logic [STOCK_W-1:0] stock_d [SLOTS];

    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic               hold_grant;

    vend_rr_arbiter #(.SLOTS(SLOTS), .IDX_W(IDX_W)) u_arb (
        .pend  (pend_q),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

`ifndef DROP_SENSE_EN
    logic unused_drop_sense;
    assign unused_drop_sense = drop_sense;
`endif

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slot_avail[i] = (stock_q[i] != '0) && !fault_q[i];
        end
    end

    assign hold_grant = (state_q == ST_MOTOR) || (state_q == ST_DROP) || (state_q == ST_DONE);

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        drop_seen_d = drop_seen_q;
        pend_d      = pend_q | sel_req;
        fault_d     = fault_q;
        stock_d     = stock_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d           = arb_grant;
                    ptr_d             = (arb_grant == IDX_W'(SLOTS - 1)) ? '0 : arb_grant + 1'b1;
                    pend_d[arb_grant] = 1'b0;
                    if (!slot_avail[arb_grant]) begin
                        state_d = ST_FAIL;
                        code_d  = FAIL_EMPTY;
                    end else begin
                        state_d = ST_DEBIT;
                    end
                end
            end
            ST_DEBIT: begin
                if (debit_nack) begin
                    state_d = ST_FAIL;
                    code_d  = FAIL_NOCREDIT;
                end else if (debit_ack) begin
                    state_d     = ST_MOTOR;
                    cnt_d       = '0;
                    drop_seen_d = 1'b0;
                end
            end
            ST_MOTOR: begin
`ifdef DROP_SENSE_EN
                if (drop_sense) drop_seen_d = 1'b1;
`endif
                if (cnt_q == CNT_W'(MOTOR_CYCLES - 1)) begin
                    cnt_d = '0;
`ifdef DROP_SENSE_EN
                    state_d = ST_DROP;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DROP_SENSE_EN
            ST_DROP: begin
                // A drop on the last timeout cycle still wins over the jam.
                if (drop_sense || drop_seen_q) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(DROP_TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                    code_d  = FAIL_JAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (stock_q[grant_q] != '0) stock_d[grant_q] = stock_q[grant_q] - 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
`ifdef DROP_SENSE_EN
                if (code_q == FAIL_JAM) fault_d[grant_q] = 1'b1;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Refill is blocked only for the slot whose can is physically in flight.
        for (int i = 0; i < SLOTS; i++) begin
            if (restock[i] && !(hold_grant && (grant_q == IDX_W'(i)))) begin
                stock_d[i] = FULL;
                fault_d[i] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            code_q      <= FAIL_NONE;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            drop_seen_q <= 1'b0;
            pend_q      <= '0;
            fault_q     <= '0;
            // NOTE: the stock array is reset because machine state must come up known (full).
            for (int i = 0; i < SLOTS; i++) stock_q[i] <= FULL;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            drop_seen_q <= drop_seen_d;
            pend_q      <= pend_d;
            fault_q     <= fault_d;
            stock_q     <= stock_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign debit_req   = (state_q == ST_DEBIT);
    assign debit_slot  = grant_q;
    assign active_slot = grant_q;
    assign motor_en    = (state_q == ST_MOTOR) ? (SLOTS'(1) << grant_q) : '0;
    assign vend_done   = (state_q == ST_DONE);
    assign vend_fail   = (state_q == ST_FAIL);
    assign fail_code   = (state_q == ST_FAIL) ? code_q : FAIL_NONE;
`ifdef DROP_SENSE_EN
    assign refund      = (state_q == ST_FAIL) && (code_q == FAIL_JAM);
`else
    assign refund      = 1'b0;
`endif

endmodule
